// File: rtl/button_pkg.sv
// Shared types and constants for the button PIO event master.
package button_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        MASK,
        RD_REQ,
        RD_WAIT,
        CLR
    } state_t;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned LAT_W  = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/button_event_master.sv
// Avalon-MM master that services an edge-capturing button PIO and turns the
// captured edges into a valid/ready event stream.
module button_event_master
    import button_pkg::*;
#(
    parameter int unsigned       WIDTH        = 2,
    parameter logic [WIDTH-1:0]  INIT_MASK    = {WIDTH{1'b1}},
    parameter int unsigned       READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [BUS_W-1:0]  avm_writedata,
    input  logic [BUS_W-1:0]  avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              pio_irq,
    input  logic [WIDTH-1:0]  cfg_mask,
    input  logic              cfg_mask_wr,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [WIDTH-1:0]  evt_data,
    output logic              evt_overrun
);

    state_t            state;
    state_t            next_state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [LAT_W-1:0]  lat_cnt_d;

    logic              mask_pend;
    logic [WIDTH-1:0]  mask_val;
    logic              mask_pend_c;
    logic [WIDTH-1:0]  mask_val_c;

    logic              accept;
    logic              sample;
    logic [WIDTH-1:0]  cap;
    logic              handshake;
    logic [WIDTH-1:0]  pend_d;
    logic              overrun_d;

    logic              read_d;
    logic              write_d;
    logic [ADDR_W-1:0] addr_d;
    logic [BUS_W-1:0]  wdata_d;

    logic              unused_readdata;
    assign unused_readdata = &{1'b0, avm_readdata[BUS_W-1:WIDTH]};

    // A request arriving this cycle is visible to IDLE immediately.
    assign mask_pend_c = mask_pend | cfg_mask_wr;
    assign mask_val_c  = cfg_mask_wr ? cfg_mask : mask_val;
    assign accept      = (avm_read | avm_write) & ~avm_waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            lat_cnt <= '0;
        end else begin
            state   <= next_state;
            lat_cnt <= lat_cnt_d;
        end
    end

    // Next state plus the bus outputs for the state being entered.
    always_comb begin
        next_state = state;
        lat_cnt_d  = lat_cnt;
        sample     = 1'b0;
        read_d     = 1'b0;
        write_d    = 1'b0;
        addr_d     = ADDR_DATA;
        wdata_d    = '0;

        case (state)
            INIT:    if (accept) next_state = IDLE;
            IDLE: begin
                if (mask_pend_c)  next_state = MASK;
                else if (pio_irq) next_state = RD_REQ;
            end
            MASK:    if (accept) next_state = IDLE;
            RD_REQ: begin
                if (accept) begin
                    next_state = RD_WAIT;
                    lat_cnt_d  = LAT_W'(READ_LATENCY);
                end
            end
            RD_WAIT: begin
                if (lat_cnt <= LAT_W'(1)) begin
                    sample     = 1'b1;
                    next_state = CLR;
                end else begin
                    lat_cnt_d = lat_cnt - LAT_W'(1);
                end
            end
            CLR:     if (accept) next_state = IDLE;
            default: next_state = INIT;
        endcase

        case (next_state)
            INIT: begin
                write_d = 1'b1;
                addr_d  = ADDR_MASK;
                wdata_d = BUS_W'(INIT_MASK);
            end
            MASK: begin
                write_d = 1'b1;
                addr_d  = ADDR_MASK;
                wdata_d = (state == MASK) ? avm_writedata : BUS_W'(mask_val_c);
            end
            RD_REQ: begin
                read_d = 1'b1;
                addr_d = ADDR_EDGE;
            end
            CLR: begin
                write_d = 1'b1;
                addr_d  = ADDR_EDGE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            avm_read      <= read_d;
            avm_write     <= write_d;
            avm_address   <= addr_d;
            avm_writedata <= wdata_d;
        end
    end

    // Mask request latch; consumed when IDLE hands off to MASK.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_pend <= 1'b0;
            mask_val  <= '0;
        end else if (state == IDLE && next_state == MASK) begin
            mask_pend <= 1'b0;
            mask_val  <= mask_val_c;
        end else if (cfg_mask_wr) begin
            mask_pend <= 1'b1;
            mask_val  <= cfg_mask;
        end
    end

    // Event register: OR-merge new captures into anything not yet accepted.
    assign cap       = sample ? avm_readdata[WIDTH-1:0] : '0;
    assign handshake = evt_valid & evt_ready;
    assign pend_d    = (handshake ? '0 : evt_data) | cap;
    assign overrun_d = sample & ~handshake & (|(evt_data & cap));

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid   <= 1'b0;
            evt_data    <= '0;
            evt_overrun <= 1'b0;
        end else begin
            evt_valid   <= |pend_d;
            evt_data    <= pend_d;
            evt_overrun <= overrun_d;
        end
    end

endmodule

// File: tb/tb_button_event_master.sv
// Self-checking bench: PIO slave model, event reference model, directed and random phases.
module tb_button_event_master;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        pio_irq;
    logic [1:0]  cfg_mask = 2'b00;
    logic        cfg_mask_wr = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [1:0]  evt_data;
    logic        evt_overrun;

    always #5 clk = ~clk;

    button_event_master dut (
        .clk             (clk),
        .reset           (reset),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .pio_irq         (pio_irq),
        .cfg_mask        (cfg_mask),
        .cfg_mask_wr     (cfg_mask_wr),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_data        (evt_data),
        .evt_overrun     (evt_overrun)
    );

    // ---------------- PIO slave model ----------------
    logic [1:0]  press    = 2'b00;
    logic        spur_req = 1'b0;
    int          wait_n   = 0;
    int          stall_cnt = 0;
    int          cyc = 0;
    logic [1:0]  s_cap  = 2'b00;
    logic [1:0]  s_mask = 2'b00;
    logic        spur   = 1'b0;
    logic        rd_ret = 1'b0;
    logic [1:0]  rd_val = 2'b00;
    logic [31:0] noise  = 32'h0;
    txn_t        log_q[$];

    logic req, acc, clr_now;
    assign req             = avm_read | avm_write;
    assign avm_waitrequest = req && (stall_cnt < wait_n);
    assign acc             = req && !avm_waitrequest;
    assign clr_now         = acc && avm_write && (avm_address == 2'd3);
    assign pio_irq         = (|(s_cap & s_mask)) | spur;
    assign avm_readdata    = rd_ret ? {noise[31:2], rd_val} : noise;

    always @(posedge clk) begin
        noise  <= $urandom;
        cyc    <= cyc + 1;
        rd_ret <= 1'b0;
        if (reset) begin
            s_cap     <= 2'b00;
            s_mask    <= 2'b00;
            spur      <= 1'b0;
            stall_cnt <= 0;
        end else begin
            s_cap <= clr_now ? 2'b00 : (s_cap | press);
            spur  <= clr_now ? 1'b0 : (spur | spur_req);
            if (acc) begin
                stall_cnt <= 0;
                log_q.push_back('{avm_write, avm_address, avm_writedata, cyc});
                if (avm_read && avm_address == 2'd3) begin
                    rd_ret <= 1'b1;
                    rd_val <= s_cap;
                end
                if (avm_write && avm_address == 2'd2) s_mask <= avm_writedata[1:0];
            end else if (req) begin
                stall_cnt <= stall_cnt + 1;
            end
        end
    end

    // Bus protocol monitor.
    int          both_hi = 0;
    int          unstable = 0;
    logic        prev_stalled = 1'b0;
    logic [35:0] prev_bus = '0;
    always @(posedge clk) begin
        if (avm_read && avm_write) both_hi <= both_hi + 1;
        if (!reset && req && prev_stalled &&
            ({avm_read, avm_write, avm_address, avm_writedata} != prev_bus))
            unstable <= unstable + 1;
        prev_stalled <= !reset && req && avm_waitrequest;
        prev_bus     <= {avm_read, avm_write, avm_address, avm_writedata};
    end

    // ---------------- Event reference model ----------------
    // Pending bits = OR of every read result not yet handed to the consumer.
    logic [1:0] m_pend = 2'b00;
    logic       m_ovr  = 1'b0;
    logic       m_hs;
    logic [1:0] m_base;
    assign m_hs   = (m_pend != 2'b00) && evt_ready;
    assign m_base = m_hs ? 2'b00 : m_pend;

    int         mdl_xfer = 0;
    int         obs_xfer = 0;
    int         obs_ovr  = 0;
    logic [1:0] last_xfer = 2'b00;

    always @(posedge clk) begin
        if (reset) begin
            m_pend <= 2'b00;
            m_ovr  <= 1'b0;
        end else begin
            if (m_hs) mdl_xfer <= mdl_xfer + 1;
            if (rd_ret) begin
                m_pend <= m_base | rd_val;
                m_ovr  <= !m_hs && ((m_pend & rd_val) != 2'b00);
            end else begin
                m_pend <= m_base;
                m_ovr  <= 1'b0;
            end
            if (evt_valid && evt_ready) begin
                obs_xfer  <= obs_xfer + 1;
                last_xfer <= evt_data;
            end
            if (evt_overrun) obs_ovr <= obs_ovr + 1;
        end
    end

    // ---------------- Checking helpers ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("evt_valid", 32'(evt_valid), 32'(m_pend != 2'b00));
        chk("evt_data", 32'(evt_data), 32'(m_pend));
        chk("evt_overrun", 32'(evt_overrun), 32'(m_ovr));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic txn_t get_txn(input int i);
        txn_t t;
        t = '{1'b0, 2'b00, 32'h0, -1};
        if (i < int'(log_q.size())) t = log_q[i];
        return t;
    endfunction

    task automatic chk_txn(input string tag, input int i, input logic we,
                           input logic [1:0] addr, input logic [31:0] data);
        txn_t t;
        t = get_txn(i);
        chk({tag, "_we"}, 32'(t.we), 32'(we));
        chk({tag, "_addr"}, 32'(t.addr), 32'(addr));
        chk({tag, "_data"}, t.data, data);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_read"}, 32'(avm_read), 32'h0);
        chk({tag, "_write"}, 32'(avm_write), 32'h0);
        chk({tag, "_addr"}, 32'(avm_address), 32'h0);
        chk({tag, "_wdata"}, avm_writedata, 32'h0);
        chk({tag, "_valid"}, 32'(evt_valid), 32'h0);
        chk({tag, "_data"}, 32'(evt_data), 32'h0);
        chk({tag, "_ovr"}, 32'(evt_overrun), 32'h0);
    endtask

    task automatic pulse_press(input logic [1:0] bits);
        press = bits;
        tick();
        press = 2'b00;
    endtask

    // ---------------- Directed and random stimulus ----------------
    initial begin
        int irq_cyc, first_v, base_x, base_o, mcyc;
        bit any_v, rd_seen;

        // Reset
        ticks(3);
        chk_idle_outputs("reset");
        reset = 1'b0;
        ticks(10);
        chk("init_count", 32'(log_q.size()), 32'd1);
        chk_txn("init", 0, 1'b1, 2'd2, 32'd3);
        chk("idle_no_read", 32'(avm_read), 32'h0);

        // Single press
        log_q.delete();
        pulse_press(2'b01);
        irq_cyc = cyc;
        chk("irq_high", 32'(pio_irq), 32'h1);
        first_v = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (evt_valid && first_v < 0) first_v = cyc;
        end
        chk_txn("sp_read", 0, 1'b0, 2'd3, 32'h0);
        chk_txn("sp_clr", 1, 1'b1, 2'd3, 32'h0);
        chk("sp_read_lat", 32'(get_txn(0).cyc - irq_cyc), 32'd1);
        chk("sp_valid_lat", 32'(first_v - get_txn(0).cyc), 32'd2);
        chk("sp_clr_lat", 32'(get_txn(1).cyc - get_txn(0).cyc), 32'd2);
        chk("sp_data", 32'(evt_data), 32'h1);
        chk("sp_irq_low", 32'(pio_irq), 32'h0);

        // Backpressure
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        base_o = obs_ovr;
        pulse_press(2'b01);
        ticks(6);
        pulse_press(2'b11);
        ticks(6);
        chk("bp_data", 32'(evt_data), 32'h3);
        chk("bp_ovr_count", 32'(obs_ovr - base_o), 32'd1);
        base_x = obs_xfer;
        evt_ready = 1'b1;
        ticks(4);
        chk("bp_xfer_count", 32'(obs_xfer - base_x), 32'd1);
        chk("bp_xfer_data", 32'(last_xfer), 32'h3);
        chk("bp_valid_low", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;

        // Simultaneous accept and merge
        pulse_press(2'b01);
        ticks(6);
        base_x = obs_xfer;
        base_o = obs_ovr;
        pulse_press(2'b10);
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("am_data", 32'(evt_data), 32'h2);
        chk("am_valid", 32'(evt_valid), 32'h1);
        chk("am_xfer_data", 32'(last_xfer), 32'h1);
        ticks(2);
        chk("am_xfer_count", 32'(obs_xfer - base_x), 32'd1);
        chk("am_no_ovr", 32'(obs_ovr - base_o), 32'd0);
        evt_ready = 1'b1;
        ticks(3);
        evt_ready = 1'b0;

        // Mask priority with waitrequest
        wait_n = 2;
        log_q.delete();
        pulse_press(2'b11);
        cfg_mask = 2'b10;
        cfg_mask_wr = 1'b1;
        mcyc = cyc;
        tick();
        cfg_mask_wr = 1'b0;
        chk("mk_issue_next", 32'(avm_write), 32'h1);
        chk("mk_issue_addr", 32'(avm_address), 32'd2);
        ticks(20);
        chk_txn("mk_write", 0, 1'b1, 2'd2, 32'd2);
        chk_txn("mk_read", 1, 1'b0, 2'd3, 32'h0);
        chk_txn("mk_clr", 2, 1'b1, 2'd3, 32'h0);
        chk("mk_accept_cyc", 32'(get_txn(0).cyc - mcyc), 32'd3);
        chk("mk_read_cyc", 32'(get_txn(1).cyc - mcyc), 32'd7);
        chk("mk_unstable", 32'(unstable), 32'd0);
        chk("mk_evt", 32'(evt_data), 32'h3);
        wait_n = 0;
        evt_ready = 1'b1;
        ticks(3);
        evt_ready = 1'b0;

        // Spurious irq
        log_q.delete();
        base_x = obs_xfer;
        spur_req = 1'b1;
        tick();
        spur_req = 1'b0;
        any_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (evt_valid) any_v = 1'b1;
        end
        chk("sp0_count", 32'(log_q.size()), 32'd2);
        chk_txn("sp0_read", 0, 1'b0, 2'd3, 32'h0);
        chk_txn("sp0_clr", 1, 1'b1, 2'd3, 32'h0);
        chk("sp0_no_valid", 32'(any_v), 32'h0);
        chk("sp0_irq_low", 32'(pio_irq), 32'h0);

        // Reset while waiting for read data; pending event is dropped
        cfg_mask = 2'b11;
        cfg_mask_wr = 1'b1;
        tick();
        cfg_mask_wr = 1'b0;
        ticks(4);
        pulse_press(2'b10);
        ticks(6);
        chk("rr_pending", 32'(evt_data), 32'h2);
        log_q.delete();
        pulse_press(2'b01);
        rd_seen = 1'b0;
        for (int i = 0; i < 10 && !rd_seen; i++) begin
            tick();
            if (log_q.size() > 0 && log_q[log_q.size() - 1].we == 1'b0) rd_seen = 1'b1;
        end
        chk("rr_read_seen", 32'(rd_seen), 32'h1);
        reset = 1'b1;
        tick();
        chk_idle_outputs("rr_reset");
        tick();
        reset = 1'b0;
        log_q.delete();
        ticks(6);
        chk_txn("rr_init", 0, 1'b1, 2'd2, 32'd3);
        chk("rr_no_evt", 32'(evt_valid), 32'h0);

        // Random traffic against the reference model
        wait_n = 1;
        for (int i = 0; i < 600; i++) begin
            press       = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            spur_req    = ($urandom_range(0, 63) == 0);
            evt_ready   = 1'($urandom_range(0, 1));
            cfg_mask_wr = ($urandom_range(0, 31) == 0);
            cfg_mask    = 2'($urandom_range(1, 3));
            tick();
        end
        press = 2'b00;
        spur_req = 1'b0;
        cfg_mask_wr = 1'b0;
        wait_n = 0;
        evt_ready = 1'b1;
        ticks(20);
        chk("rnd_xfers", 32'(obs_xfer), 32'(mdl_xfer));
        chk("rnd_unstable", 32'(unstable), 32'd0);
        chk("rd_wr_exclusive", 32'(both_hi), 32'd0);
        chk("rnd_drained", 32'(evt_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
